// File: rtl/sram_tp_be_behave_pkg.sv
// Shared definitions for the two-port column-enable SRAM model.
//   clr_state_e  : clear-sequencer FSM states (CLR zeroes the array, RUN serves accesses)
//   rd_lat_legal : elaboration-time check of the read-latency parameter
package sram_tp_be_behave_pkg;

  typedef enum logic {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } clr_state_e;

  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/sram_tp_be_behave_clr_ctl.sv
// Clear sequencer for sram_tp_be_behave.
// Owns the CLR/RUN state machine and the clear address counter, and merges the
// zero-write of the sequencer with the user write port so the array sees a
// single write port.
// Ports:
//   clk, rstn   clock / asynchronous active-low reset
//   i_clr_req   one-cycle request to re-clear the array (ignored while clearing)
//   o_clr_bsy   high while the sequencer owns the array
//   i_wr_*      user write port (address, column enables, data)
//   i_rd_ena    user read request
//   o_mem_*     merged write port driven into the array
//   o_rd_acc    user read accepted this cycle
module sram_clr_ctl
  import sram_tp_be_behave_pkg::*;
#(
  parameter int ADR_WD  = 5,
  parameter int ADR     = 1 << ADR_WD,
  parameter int DAT_WD  = 8,
  parameter int NCOL    = 1,
  parameter int CLR_ENA = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clr_req,
  output logic              o_clr_bsy,
  input  logic [ADR_WD-1:0] i_wr_adr,
  input  logic [NCOL-1:0]   i_wr_ena,
  input  logic [DAT_WD-1:0] i_wr_dat,
  input  logic              i_rd_ena,
  output logic [ADR_WD-1:0] o_mem_adr,
  output logic [NCOL-1:0]   o_mem_ena,
  output logic [DAT_WD-1:0] o_mem_dat,
  output logic              o_rd_acc
);

  localparam clr_state_e        RST_STATE = (CLR_ENA != 0) ? ST_CLR : ST_RUN;
  localparam logic [ADR_WD-1:0] LAST_ADR  = ADR_WD'(ADR - 1);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADR_WD-1:0] r_clr_adr;
  logic [ADR_WD-1:0] w_clr_adr_nxt;
  logic              w_bsy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of process order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= RST_STATE;
      r_clr_adr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_adr <= w_clr_adr_nxt;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_adr_nxt = r_clr_adr;
    case (r_state)
      ST_CLR: begin
        if (r_clr_adr == LAST_ADR) begin
          w_state_nxt   = ST_RUN;
          w_clr_adr_nxt = '0;
        end else begin
          w_clr_adr_nxt = r_clr_adr + ADR_WD'(1);
        end
      end
      ST_RUN: begin
        if (i_clr_req && (CLR_ENA != 0)) w_state_nxt = ST_CLR;
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  assign w_bsy     = (r_state == ST_CLR);
  assign o_clr_bsy = w_bsy;

  // While clearing, the sequencer takes the write port with all columns
  // enabled and zero data; user traffic is dropped.
  assign o_mem_adr = w_bsy ? r_clr_adr : i_wr_adr;
  assign o_mem_ena = w_bsy ? {NCOL{1'b1}} : i_wr_ena;
  assign o_mem_dat = w_bsy ? '0 : i_wr_dat;
  assign o_rd_acc  = i_rd_ena & ~w_bsy;

endmodule

// File: rtl/sram_tp_be_behave.sv
// Behavioural two-port (1R/1W) SRAM with per-column write enables, a 1- or
// 2-cycle registered read path with valid flag, selectable read-during-write
// behaviour and a clear sequencer that zeroes the array after reset or on
// request.
// Ports:
//   clk, rstn        clock / asynchronous active-low reset
//   clr_req/clr_bsy  clear request in, clear-in-progress out
//   wr_adr/wr_ena/wr_dat   write address, per-column enables, data
//   rd_adr/rd_ena          read address and request
//   rd_val/rd_dat          read valid and data (data is zero when not valid)
module sram_tp_be_behave
  import sram_tp_be_behave_pkg::*;
#(
  parameter int ADR_WD  = 5,
  parameter int ADR     = 1 << ADR_WD,
  parameter int DAT_WD  = 8,
  parameter int COL_WD  = 8,
  parameter int RD_LAT  = 1,
  parameter int BYPASS  = 1,
  parameter int CLR_ENA = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr_req,
  output logic                     clr_bsy,
  input  logic [ADR_WD-1:0]        wr_adr,
  input  logic [DAT_WD/COL_WD-1:0] wr_ena,
  input  logic [DAT_WD-1:0]        wr_dat,
  input  logic [ADR_WD-1:0]        rd_adr,
  input  logic                     rd_ena,
  output logic                     rd_val,
  output logic [DAT_WD-1:0]        rd_dat
);

  localparam int                NCOL    = DAT_WD / COL_WD;
  localparam logic [ADR_WD:0]   ADR_LIM = (ADR_WD + 1)'(ADR);

  if (!rd_lat_legal(RD_LAT)) begin : g_chk_lat
    $error("sram_tp_be_behave: RD_LAT=%0d is illegal, must be 1 or 2", RD_LAT);
  end
  if ((DAT_WD % COL_WD) != 0) begin : g_chk_col
    $error("sram_tp_be_behave: DAT_WD=%0d is not a multiple of COL_WD=%0d", DAT_WD, COL_WD);
  end
`ifndef BEHAVE_MODEL
  if (1) begin : g_banner
    $info("calling sram_tp_be_behave @%m");
  end
`endif

  logic [ADR_WD-1:0] w_mem_adr;
  logic [NCOL-1:0]   w_mem_ena;
  logic [DAT_WD-1:0] w_mem_dat;
  logic              w_rd_acc;
  logic [DAT_WD-1:0] w_rd_word;
  logic              r_s1_val;
  logic [DAT_WD-1:0] r_s1_dat;
  logic [DAT_WD-1:0] r_mem [ADR];

  sram_clr_ctl #(
    .ADR_WD  (ADR_WD),
    .ADR     (ADR),
    .DAT_WD  (DAT_WD),
    .NCOL    (NCOL),
    .CLR_ENA (CLR_ENA)
  ) u_clr_ctl (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr_req (clr_req),
    .o_clr_bsy (clr_bsy),
    .i_wr_adr  (wr_adr),
    .i_wr_ena  (wr_ena),
    .i_wr_dat  (wr_dat),
    .i_rd_ena  (rd_ena),
    .o_mem_adr (w_mem_adr),
    .o_mem_ena (w_mem_ena),
    .o_mem_dat (w_mem_dat),
    .o_rd_acc  (w_rd_acc)
  );

  // NOTE: the array is deliberately not reset; zeroing it is the clear
  // sequencer's job, which keeps the storage mappable onto RAM primitives.
  always_ff @(posedge clk) begin
    if ({1'b0, w_mem_adr} < ADR_LIM) begin
      for (int i = 0; i < NCOL; i++) begin
        if (w_mem_ena[i]) r_mem[w_mem_adr][i*COL_WD +: COL_WD] <= w_mem_dat[i*COL_WD +: COL_WD];
      end
    end
  end

  // Read word as seen at this edge. Reads are only accepted in RUN, so the raw
  // user write port is the one that can collide. Out-of-range reads give zero.
  always_comb begin
    w_rd_word = '0;
    if ({1'b0, rd_adr} < ADR_LIM) begin
      w_rd_word = r_mem[rd_adr];
      if ((BYPASS != 0) && (rd_adr == wr_adr)) begin
        for (int i = 0; i < NCOL; i++) begin
          if (wr_ena[i]) w_rd_word[i*COL_WD +: COL_WD] = wr_dat[i*COL_WD +: COL_WD];
        end
      end
    end
  end

  // First output stage; data is forced to zero on cycles without a valid read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_val <= 1'b0;
      r_s1_dat <= '0;
    end else begin
      r_s1_val <= w_rd_acc;
      r_s1_dat <= w_rd_acc ? w_rd_word : '0;
    end
  end

  // The pipeline is not gated by the clear state, so reads in flight when a
  // clear starts still deliver their captured data.
  if (RD_LAT == 2) begin : g_lat2
    logic              r_s2_val;
    logic [DAT_WD-1:0] r_s2_dat;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_s2_val <= 1'b0;
        r_s2_dat <= '0;
      end else begin
        r_s2_val <= r_s1_val;
        r_s2_dat <= r_s1_dat;
      end
    end

    assign rd_val = r_s2_val;
    assign rd_dat = r_s2_dat;
  end else begin : g_lat1
    assign rd_val = r_s1_val;
    assign rd_dat = r_s1_dat;
  end

endmodule
